// File: rtl/popcount_pkg.sv
// popcount_pkg: shared state encoding, default widths and sizing helpers
// for the chunked popcount engine.
package popcount_pkg;

    localparam int DATA_W_DEF  = 64;
    localparam int CHUNK_W_DEF = 16;
    localparam int COUNT_W_DEF = $clog2(DATA_W_DEF + 1);

    typedef enum logic [1:0] {
        PC_IDLE  = 2'd0,
        PC_COUNT = 2'd1,
        PC_DONE  = 2'd2
    } pc_state_t;

    // Result type for the default operand width.
    typedef logic [COUNT_W_DEF-1:0] pc_count_t;

    // Number of COUNT cycles needed to walk an operand chunk by chunk.
    function automatic int num_chunks(input int data_w, input int chunk_w);
        return data_w / chunk_w;
    endfunction

    localparam int NUM_CHUNKS = num_chunks(DATA_W_DEF, CHUNK_W_DEF);

endpackage

// File: rtl/popcount_chunk.sv
// popcount_chunk: purely combinational population count of one CHUNK_W-bit slice.
module popcount_chunk
    import popcount_pkg::*;
#(
    parameter int CHUNK_W = CHUNK_W_DEF,
    parameter int CNT_W   = $clog2(CHUNK_W + 1)
)(
    input  logic [CHUNK_W-1:0] i_bits,
    output logic [CNT_W-1:0]   o_count
);

    // Reduction sum of the chunk bits; synthesis balances this into an adder tree.
    always_comb begin
        // NOTE: every combinational output gets a default first, so no path can infer a latch.
        o_count = '0;
        for (int i = 0; i < CHUNK_W; i++) begin
            o_count = o_count + CNT_W'(i_bits[i]);
        end
    end

endmodule

// File: rtl/popcount_chunked.sv
// popcount_chunked: multi-cycle population count / Hamming distance engine.
// Walks the latched operand CHUNK_W bits per cycle, with valid/ready on both sides.
// Optional macro POPCNT_EARLY_EXIT_EN: finish as soon as the remaining data is zero.
module popcount_chunked
    import popcount_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int CHUNK_W = CHUNK_W_DEF,
    parameter int COUNT_W = $clog2(DATA_W + 1)
)(
    input  logic               clk,
    input  logic               rst,
    input  logic               in_vld,
    output logic               in_rdy,
    input  logic               mode_i,
    input  logic [DATA_W-1:0]  a_i,
    input  logic [DATA_W-1:0]  b_i,
    output logic               out_vld,
    input  logic               out_rdy,
    output logic [COUNT_W-1:0] count_o
);

    localparam int N      = num_chunks(DATA_W, CHUNK_W);
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;
    localparam int CCNT_W = $clog2(CHUNK_W + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    if (DATA_W % CHUNK_W != 0) begin : g_width_check
        $error("popcount_chunked: DATA_W (%0d) must be a multiple of CHUNK_W (%0d)", DATA_W, CHUNK_W);
    end

    pc_state_t          r_state;
    pc_state_t          w_state_nxt;
    logic [DATA_W-1:0]  r_data;
    logic [COUNT_W-1:0] r_count;
    logic [IDX_W-1:0]   r_idx;
    logic [CCNT_W-1:0]  w_chunk_cnt;
    logic               w_accept;
    logic               w_last;

    popcount_chunk #(
        .CHUNK_W (CHUNK_W),
        .CNT_W   (CCNT_W)
    ) u_chunk (
        .i_bits  (r_data[CHUNK_W-1:0]),
        .o_count (w_chunk_cnt)
    );

    assign w_accept = (r_state == PC_IDLE) && in_vld;

`ifdef POPCNT_EARLY_EXIT_EN
    // Stop once the data left after this cycle's shift holds no set bits.
    assign w_last = (r_idx == LAST_IDX) || ((r_data >> CHUNK_W) == '0);
`else
    assign w_last = (r_idx == LAST_IDX);
`endif

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_state <= PC_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        in_rdy      = 1'b0;
        out_vld     = 1'b0;
        case (r_state)
            PC_IDLE: begin
                in_rdy = 1'b1;
                if (in_vld) begin
                    w_state_nxt = PC_COUNT;
                end
            end
            PC_COUNT: begin
                if (w_last) begin
                    w_state_nxt = PC_DONE;
                end
            end
            PC_DONE: begin
                out_vld = 1'b1;
                if (out_rdy) begin
                    w_state_nxt = PC_IDLE;
                end
            end
            default: w_state_nxt = PC_IDLE;
        endcase
    end

    // Operand latch, chunk shifter and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_data  <= '0;
            r_count <= '0;
            r_idx   <= '0;
        end else if (w_accept) begin
            r_data  <= mode_i ? (a_i ^ b_i) : a_i;
            r_count <= '0;
            r_idx   <= '0;
        end else if (r_state == PC_COUNT) begin
            r_count <= r_count + COUNT_W'(w_chunk_cnt);
            r_data  <= r_data >> CHUNK_W;
            r_idx   <= r_idx + IDX_W'(1);
        end
    end

    // The accumulator doubles as the result; it holds until the next accept.
    assign count_o = r_count;

endmodule
